l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Two-client arbiter directly upstream of the L2 cache. It merges the instruction-fetch port (client A) and the data-access port (client B) onto the single L2 CPU bus.
- Guarantees the L2 bus contract:
  - rising-edge start;
  - address, data and we stable for the whole transaction;
  - start low for at least one cycle between transactions;
  - one-cycle done pulse.
- Round-robin arbitration, registered outputs both sides, flush-safe result discard.

Parameters:
- ADDR_W, 24, word address width (matches L2 bus)
- DATA_W, 32, data word width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- a_addr  input  ADDR_W  client A address
- a_data  input  DATA_W  client A write data
- a_we  input  1  client A write enable
- a_start  input  1  client A request level; held until a_done or withdrawn
- a_q  output  DATA_W  client A read data; valid while a_done=1
- a_done  output  1  client A one-cycle completion pulse
- b_addr, b_data, b_we, b_start, b_q, b_done  same as the client A ports, for client B
- l2_addr  output  ADDR_W  to L2 cache
- l2_data  output  DATA_W  to L2 cache
- l2_we  output  1  to L2 cache
- l2_start  output  1  to L2 cache, level for the whole transaction
- l2_q  input  DATA_W  from L2 cache
- l2_done  input  1  from L2 cache, one-cycle pulse

Behaviour:
- Reset (async assert, sync release): all outputs 0; state=IDLE; last_grant=B, so A wins the first tie; discard flag 0.
- States (2-bit, encodings in package): IDLE, ISSUE, RESP, GAP.
- IDLE:
  - Evaluate effective requests: req_x = x_start AND NOT mask_x.
  - Only A requesting → grant A. Only B → grant B. Both → the client not equal to last_grant.
  - On grant: latch addr, data and we into the l2_* registers; l2_start<=1; grant<=x; last_grant<=x; go to ISSUE.
  - l2_start therefore rises one cycle after the request is sampled.
- ISSUE:
  - Hold l2_* stable.
  - If the granted client's start is 0 in any cycle, set discard=1. The transaction is never aborted, because L2 may already be writing SDRAM.
  - On l2_done=1: l2_start<=0; capture l2_q into the granted client's q register; go to RESP.
- RESP:
  - If discard=0, the granted x_done=1 for exactly this cycle, with x_q valid. If discard=1, no done pulse and x_q keeps its old value.
  - Set mask_x=1 for the served client; clear discard; go to GAP.
- GAP:
  - l2_start stays 0, guaranteeing at least 2 low cycles (RESP and GAP) before the next rising edge.
  - Clear mask_x at exit; go to IDLE.
- Client handshake:
  - Client must drop x_start in the cycle after x_done. The mask covers that cycle, so a late-dropping client is not re-served.
- Latency: request sampled in IDLE at cycle 0 → l2_start=1 at cycle 1 → l2_done at cycle N → x_done at cycle N+1. Minimum request-to-done is 4 cycles given the 2-cycle L2 hit path.
- Simultaneous events:
  - l2_done and withdrawal of start in the same cycle count as a withdrawal: discard, no done.
  - Requests arriving during ISSUE, RESP or GAP wait; they are not lost, because start is a level.
- l2_done outside ISSUE is ignored.
- l2_q is never forwarded combinationally.
- Writes: x_done pulses the same way; x_q is updated with l2_q, whose value is don't-care.
- Reset mid-transaction: immediate return to reset values. l2_start falling is acceptable; the L2 cache is reset from the same source.

Decomposition:
- Shared package (l2_bus_pkg):
  - ADDR_W and DATA_W constants;
  - arbiter state encodings;
  - client-id constants CLIENT_A=0 and CLIENT_B=1.
- One sub-module, l2_arb_port, instantiated twice. It holds one client's:
  - mask flag;
  - q register;
  - done-pulse generation;
  - effective-request output.
- The top module holds the FSM, the round-robin bit and the l2_* registers.

Test Plan:
- A read alone, a_addr=0x000123: l2_start rises 1 cycle after a_start, with l2_addr=0x000123 and l2_we=0. Bench returns l2_done with l2_q=0xDEADBEEF. a_done=1 one cycle later with a_q=0xDEADBEEF; b_done stays 0.
- A and B both assert in the same cycle from reset: A is served first, then B, with l2_start low for ≥2 cycles between them. Third round with both asserting again: A is served, because last_grant=B.
- B write, b_addr=0x7FFFFF, b_data=0x12345678: l2_we=1, and l2_addr/l2_data are stable every cycle until l2_done (bench delays 20 cycles). b_done pulses once.
- Flush: A drops a_start 2 cycles into ISSUE. The L2 transaction completes, a_done never pulses, and a_q is unchanged. The next B request is served normally.
- Late-dropping client: A holds a_start 1 cycle past a_done. No second L2 transaction is issued for A.
- Reset asserted asynchronously mid-ISSUE: all outputs 0 without a clock edge. After release, the FSM is in IDLE and the first tie goes to A.

Source files
------------

// File: rtl/l2_bus_pkg.sv
// Shared L2 CPU bus constants: widths, arbiter state encodings, client ids.
// No logic; no latency; no backpressure.
// Imported by the arbiter top and its per-client port.
package l2_bus_pkg;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;
endpackage

// File: rtl/l2_arb_port.sv
// One client's side of the arbiter: re-serve mask, read-data register, done pulse.
// Latency: done/q are registered, one cycle after the completing l2_done.
// Backpressure: none; the client holds its start level until done or withdrawal.
module l2_arb_port #(
    parameter int DATA_W = l2_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              complete,
    input  logic              mask_set,
    input  logic              mask_clr,
    input  logic [DATA_W-1:0] l2_q,
    output logic              req,
    output logic [DATA_W-1:0] q,
    output logic              done
);
    logic mask;

    assign req = start & ~mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= 1'b0;
            q    <= '0;
            done <= 1'b0;
        end else begin
            done <= complete;
            if (complete) begin
                q <= l2_q;
            end
            // Mask spans the cycle after done so a slow-dropping start is not re-granted.
            if (mask_set) begin
                mask <= 1'b1;
            end else if (mask_clr) begin
                mask <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/l2_arbiter.sv
// Round-robin merge of fetch (A) and data (B) clients onto the single L2 CPU bus.
// Latency: l2_start one cycle after request sampled; x_done one cycle after l2_done.
// Backpressure: requests are levels and wait through ISSUE/RESP/GAP; a withdrawn grant completes silently.
module l2_arbiter #(
    parameter int ADDR_W = l2_bus_pkg::ADDR_W,
    parameter int DATA_W = l2_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_done,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_done,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_data,
    output logic              l2_we,
    output logic              l2_start,
    input  logic [DATA_W-1:0] l2_q,
    input  logic              l2_done
);
    import l2_bus_pkg::*;

    arb_state_t state;
    logic       grant;
    logic       last_grant;
    logic       discard;
    logic       a_req;
    logic       b_req;
    logic       pick;
    logic       grant_start;
    logic       served;

    assign grant_start = (grant == CLIENT_B) ? b_start : a_start;
    // A withdrawal in the same cycle as l2_done still suppresses the done pulse.
    assign served      = (state == ST_ISSUE) && l2_done && grant_start && !discard;
    assign pick        = (a_req && b_req) ? ~last_grant : (b_req ? CLIENT_B : CLIENT_A);

    l2_arb_port #(.DATA_W(DATA_W)) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .start    (a_start),
        .complete (served && (grant == CLIENT_A)),
        .mask_set ((state == ST_RESP) && (grant == CLIENT_A)),
        .mask_clr (state == ST_GAP),
        .l2_q     (l2_q),
        .req      (a_req),
        .q        (a_q),
        .done     (a_done)
    );

    l2_arb_port #(.DATA_W(DATA_W)) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .start    (b_start),
        .complete (served && (grant == CLIENT_B)),
        .mask_set ((state == ST_RESP) && (grant == CLIENT_B)),
        .mask_clr (state == ST_GAP),
        .l2_q     (l2_q),
        .req      (b_req),
        .q        (b_q),
        .done     (b_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= CLIENT_A;
            last_grant <= CLIENT_B;
            discard    <= 1'b0;
            l2_addr    <= '0;
            l2_data    <= '0;
            l2_we      <= 1'b0;
            l2_start   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        l2_addr    <= (pick == CLIENT_B) ? b_addr : a_addr;
                        l2_data    <= (pick == CLIENT_B) ? b_data : a_data;
                        l2_we      <= (pick == CLIENT_B) ? b_we : a_we;
                        l2_start   <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Never abort: the L2 may already be committing a write.
                    if (!grant_start) begin
                        discard <= 1'b1;
                    end
                    if (l2_done) begin
                        l2_start <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    discard <= 1'b0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: table-driven single transactions, directed corner sequences,
// then random two-client traffic against a transaction-level reference model.
module tb_l2_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] a_addr, b_addr, l2_addr;
    logic [31:0] a_data, b_data, l2_data, a_q, b_q, l2_q;
    logic        a_we, b_we, a_start, b_start, a_done, b_done;
    logic        l2_we, l2_start, l2_done;

    l2_arbiter dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_start(a_start), .a_q(a_q), .a_done(a_done),
        .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_start(b_start), .b_q(b_q), .b_done(b_done),
        .l2_addr(l2_addr), .l2_data(l2_data), .l2_we(l2_we), .l2_start(l2_start),
        .l2_q(l2_q), .l2_done(l2_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cl;
        logic [23:0] addr;
        logic [31:0] data;
        bit          we;
        int          delay;
        logic [31:0] rq;
        logic [23:0] x_addr;
        bit          x_we;
        logic [31:0] x_q;
    } vec_t;

    vec_t        tbl[5];
    vec_t        v;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lows;
    bit          seen;
    logic [31:0] last_a_q;

    // random-phase reference model state
    bit          m_busy, m_grant, m_last, m_wd, m_we, done_drv, exp_start, w;
    int          lo_cnt, resp_cnt;
    logic [23:0] m_addr;
    logic [31:0] m_data, q_drv;
    bit          exp_done[2];
    logic [31:0] exp_q[2];
    bit          cs_start[2];
    bit          ca_we[2];
    logic [23:0] ca_addr[2];
    logic [31:0] ca_data[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs;
        a_addr = '0; a_data = '0; a_we = 0; a_start = 0;
        b_addr = '0; b_data = '0; b_we = 0; b_start = 0;
        l2_q = '0; l2_done = 0;
    endtask

    task automatic do_reset;
        reset = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic run_txn(input vec_t t, input bit late);
        bit stable;
        if (t.cl) begin b_addr = t.addr; b_data = t.data; b_we = t.we; b_start = 1; end
        else      begin a_addr = t.addr; a_data = t.data; a_we = t.we; a_start = 1; end
        @(negedge clk);
        chk("txn_rise", 32'(l2_start), 32'd1);
        chk("txn_addr", 32'(l2_addr), 32'(t.x_addr));
        chk("txn_we", 32'(l2_we), 32'(t.x_we));
        chk("txn_data", l2_data, t.data);
        stable = 1;
        for (int i = 1; i < t.delay; i++) begin
            @(negedge clk);
            if (l2_start !== 1'b1 || l2_addr !== t.x_addr || l2_data !== t.data || l2_we !== t.x_we)
                stable = 0;
        end
        chk("txn_hold_stable", 32'(stable), 32'd1);
        l2_done = 1; l2_q = t.rq;
        @(negedge clk);
        l2_done = 0; l2_q = '0;
        chk("txn_done", 32'(t.cl ? b_done : a_done), 32'd1);
        chk("txn_other_done", 32'(t.cl ? a_done : b_done), 32'd0);
        chk("txn_q", t.cl ? b_q : a_q, t.x_q);
        chk("txn_l2_start_fall", 32'(l2_start), 32'd0);
        if (!late) begin a_start = 0; b_start = 0; end
        @(negedge clk);
        chk("txn_done_one_cycle", 32'(t.cl ? b_done : a_done), 32'd0);
        @(negedge clk);
        a_start = 0; b_start = 0;
    endtask

    initial begin
        tbl[0] = '{0, 24'h000123, 32'h00000000, 0,  2, 32'hDEADBEEF, 24'h000123, 0, 32'hDEADBEEF};
        tbl[1] = '{1, 24'h7FFFFF, 32'h12345678, 1, 20, 32'hA5A5A5A5, 24'h7FFFFF, 1, 32'hA5A5A5A5};
        tbl[2] = '{0, 24'hABCDEF, 32'h55AA55AA, 1,  3, 32'h0BADF00D, 24'hABCDEF, 1, 32'h0BADF00D};
        tbl[3] = '{1, 24'h000001, 32'hFFFFFFFF, 0,  1, 32'hCAFEF00D, 24'h000001, 0, 32'hCAFEF00D};
        tbl[4] = '{0, 24'h400000, 32'h00000000, 0,  5, 32'h13579BDF, 24'h400000, 0, 32'h13579BDF};

        reset = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_l2_start", 32'(l2_start), 32'd0);
        chk("reset_l2_addr", 32'(l2_addr), 32'd0);
        chk("reset_l2_data", l2_data, 32'd0);
        chk("reset_l2_we", 32'(l2_we), 32'd0);
        chk("reset_done", 32'({a_done, b_done}), 32'd0);
        chk("reset_q", a_q | b_q, 32'd0);
        reset = 1;

        // tie from reset: A, then B after a >=2-cycle low gap, then A again
        a_addr = 24'h0000AA; a_data = 32'h1; a_we = 0;
        b_addr = 24'h0000BB; b_data = 32'h2; b_we = 1;
        a_start = 1; b_start = 1;
        @(negedge clk);
        chk("tie1_winner_a", 32'(l2_addr), 32'h0000AA);
        @(negedge clk);
        l2_done = 1; l2_q = 32'h111;
        @(negedge clk);
        l2_done = 0;
        chk("tie1_a_done", 32'({a_done, b_done}), 32'b10);
        a_start = 0;
        lows = 1;
        while (l2_start !== 1'b1 && lows < 30) begin
            @(negedge clk);
            if (l2_start !== 1'b1) lows++;
        end
        chk("tie2_gap_ge2", 32'(lows >= 2), 32'd1);
        chk("tie2_winner_b", 32'(l2_addr), 32'h0000BB);
        chk("tie2_we", 32'(l2_we), 32'd1);
        @(negedge clk);
        l2_done = 1; l2_q = 32'h222;
        @(negedge clk);
        l2_done = 0;
        chk("tie2_b_done", 32'({a_done, b_done}), 32'b01);
        chk("tie2_b_q", b_q, 32'h222);
        b_start = 0;
        repeat (2) @(negedge clk);
        a_start = 1; b_start = 1;
        @(negedge clk);
        chk("tie3_winner_a", 32'(l2_addr), 32'h0000AA);
        @(negedge clk);
        l2_done = 1; l2_q = 32'h333;
        @(negedge clk);
        l2_done = 0;
        chk("tie3_a_done", 32'({a_done, b_done}), 32'b10);
        a_start = 0; b_start = 0;
        repeat (2) @(negedge clk);

        last_a_q = 32'h333;
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i], 1'b0);
            if (!tbl[i].cl) last_a_q = tbl[i].x_q;
        end

        // flush: A withdraws mid-ISSUE; L2 still completes, A gets nothing
        a_addr = 24'h000456; a_we = 0; a_start = 1;
        @(negedge clk);
        chk("flush_rise", 32'(l2_start), 32'd1);
        @(negedge clk);
        a_start = 0;
        repeat (2) @(negedge clk);
        chk("flush_not_aborted", 32'(l2_start), 32'd1);
        l2_done = 1; l2_q = 32'h99999999;
        @(negedge clk);
        l2_done = 0;
        chk("flush_no_done", 32'(a_done), 32'd0);
        chk("flush_q_kept", a_q, last_a_q);
        chk("flush_l2_start_low", 32'(l2_start), 32'd0);
        @(negedge clk);
        chk("flush_no_late_done", 32'(a_done), 32'd0);
        @(negedge clk);
        v = '{1, 24'h000777, 32'h0, 0, 2, 32'h77777777, 24'h000777, 0, 32'h77777777};
        run_txn(v, 1'b0);

        // late-dropping client: start held through the cycle after done
        v = '{0, 24'h000888, 32'h0, 0, 2, 32'h88888888, 24'h000888, 0, 32'h88888888};
        run_txn(v, 1'b1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (l2_start) seen = 1;
        end
        chk("late_no_reissue", 32'(seen), 32'd0);

        // async reset mid-ISSUE, then the first tie must go to A
        a_addr = 24'h0000CC; a_data = 32'h12; a_start = 1;
        @(negedge clk);
        chk("areset_pre_rise", 32'(l2_start), 32'd1);
        #2 reset = 0;
        #1;
        chk("areset_l2_start", 32'(l2_start), 32'd0);
        chk("areset_l2_addr", 32'(l2_addr), 32'd0);
        chk("areset_l2_data", l2_data, 32'd0);
        chk("areset_a_q", a_q, 32'd0);
        chk("areset_flags", 32'({a_done, b_done, l2_we}), 32'd0);
        a_start = 0;
        @(negedge clk);
        reset = 1;
        a_addr = 24'h0000A1; b_addr = 24'h0000B1; a_start = 1; b_start = 1;
        @(negedge clk);
        chk("areset_tie_winner_a", 32'(l2_addr), 32'h0000A1);
        @(negedge clk);
        l2_done = 1; l2_q = 32'h4;
        @(negedge clk);
        l2_done = 0;
        chk("areset_tie_a_done", 32'({a_done, b_done}), 32'b10);
        a_start = 0; b_start = 0;
        repeat (2) @(negedge clk);

        // random traffic against a transaction-level model
        do_reset();
        m_busy = 0; m_last = 1; m_wd = 0; lo_cnt = 3; done_drv = 0; resp_cnt = 0;
        m_grant = 0; m_addr = '0; m_data = '0; m_we = 0; q_drv = '0;
        for (int c = 0; c < 2; c++) begin
            exp_q[c] = '0; cs_start[c] = 0; ca_addr[c] = '0; ca_data[c] = '0; ca_we[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_done[0] = 0; exp_done[1] = 0;
            if (m_busy) begin
                if (done_drv) begin
                    m_busy = 0;
                    exp_start = 0;
                    if (!m_wd) begin
                        exp_done[m_grant] = 1;
                        exp_q[m_grant] = q_drv;
                    end
                end else begin
                    exp_start = 1;
                end
            end else if (lo_cnt >= 3 && (cs_start[0] || cs_start[1])) begin
                w = (cs_start[0] && cs_start[1]) ? !m_last : cs_start[1];
                m_grant = w; m_last = w; m_busy = 1; m_wd = 0;
                m_addr = ca_addr[w]; m_data = ca_data[w]; m_we = ca_we[w];
                resp_cnt = int'($urandom_range(1, 6));
                exp_start = 1;
            end else begin
                exp_start = 0;
            end
            lo_cnt = exp_start ? 0 : (lo_cnt < 3 ? lo_cnt + 1 : 3);

            chk("rnd_l2_start", 32'(l2_start), 32'(exp_start));
            if (exp_start) begin
                chk("rnd_l2_addr", 32'(l2_addr), 32'(m_addr));
                chk("rnd_l2_data", l2_data, m_data);
                chk("rnd_l2_we", 32'(l2_we), 32'(m_we));
            end
            chk("rnd_a_done", 32'(a_done), 32'(exp_done[0]));
            chk("rnd_b_done", 32'(b_done), 32'(exp_done[1]));
            chk("rnd_a_q", a_q, exp_q[0]);
            chk("rnd_b_q", b_q, exp_q[1]);

            done_drv = 0;
            l2_done = 0;
            l2_q = $urandom;
            if (m_busy) begin
                if (resp_cnt == 0) begin
                    l2_done = 1; done_drv = 1; q_drv = l2_q;
                end else begin
                    resp_cnt--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                l2_done = 1;
            end
            for (int c = 0; c < 2; c++) begin
                if (cs_start[c]) begin
                    if (exp_done[c] || $urandom_range(0, 39) == 0) cs_start[c] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cs_start[c] = 1;
                    ca_addr[c] = 24'($urandom);
                    ca_data[c] = $urandom;
                    ca_we[c] = 1'($urandom_range(0, 1));
                end
            end
            if (m_busy && !cs_start[m_grant]) m_wd = 1;
            a_start = cs_start[0]; a_addr = ca_addr[0]; a_data = ca_data[0]; a_we = ca_we[0];
            b_start = cs_start[1]; b_addr = ca_addr[1]; b_data = ca_data[1]; b_we = ca_we[1];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
